alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU, the successor of the single-cycle 64-bit datapath ALU. It keeps the existing AND/ORR/ADD/SUB/pass-B encodings and adds iterative unsigned multiply and divide. It adds full NZCV flags and a valid/ready handshake on both sides. It sits between the register-read stage and the writeback mux; the control unit stalls issue while `in_ready` is low.

## Interface
- `N`, 64: operand/result width (≥ 8)
- `CW`, $clog2(N+1): width of the iteration counter
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block can accept an operation
- `a`, `b`  in  N each  operands, sampled on accept
- `ALUControl`  in  4  operation code, sampled on accept
- `out_valid`  out  1  result and flags are valid
- `out_ready`  in  1  consumer takes the result
- `result`  out  N  operation result
- `zero`, `negative`, `carry`, `overflow`  out  1 each  flags for `result`

## Operation
- Accept happens when `in_valid && in_ready`; completion happens when `out_valid && out_ready`.
- Codes:
  - 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (a−b); 0111 pass b
  - 1000 MUL: low N bits of unsigned a×b
  - 1001 UDIV: unsigned a/b
  - any other code: `result` is all ones
- `zero` = (`result` == 0) for every code. `negative` = `result[N-1]` for every code.
- ADD: `carry` = carry-out of bit N-1; `overflow` = signed overflow.
- SUB: `carry` = NOT borrow (set when a ≥ b unsigned); `overflow` = signed overflow.
- All other codes: `carry` = `overflow` = 0.
- UDIV with b == 0: `result` = all ones, `carry` = 1 (divide-by-zero indication), `overflow` = 0, no iteration (single-cycle path).
- FSM:
  - IDLE: `in_ready` = 1. On accept, a simple op (or divide-by-zero) goes to DONE. MUL/UDIV load the operands and counter = N, then go to BUSY.
  - BUSY: one shift-add step (MUL) or one restoring subtract-shift step (UDIV) per cycle; counter decrements. When the counter reaches 1 the last step completes and the FSM goes to DONE.
  - DONE: `out_valid` = 1. On `out_ready` go to IDLE.
- `in_ready` is high only in IDLE; there are no overlapping operations.
- `result` and flags are registered and stay stable throughout DONE until completion.
- Operand and opcode changes outside accept cycles are ignored.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, all flags = 0, counter = 0.
- Simple op accepted at edge k: `out_valid` is high from after edge k+1.
- MUL/UDIV accepted at edge k: `out_valid` is high after edge k+N+1, i.e. N BUSY cycles. Divide-by-zero follows the simple-op timing.
- If `out_ready` is already high when `out_valid` rises, completion happens at that next edge. The next accept is possible one cycle later, since IDLE must be re-entered first.
- `reset` asserted in any state, including mid-BUSY, returns all outputs to reset values at the next edge. The partial result is discarded and no `out_valid` pulse is produced.
- `in_valid` high in BUSY or DONE has no effect; the operation stays pending upstream.

## Structure
- `alu_pkg`: localparams for the opcodes (ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_MUL, ALU_UDIV), the state enum `alu_state_t` {IDLE, BUSY, DONE}, and a `flags_t` struct {n, z, c, v}.
- Sub-module `alu_core`: purely combinational N-bit AND/ORR/ADD/SUB/pass-B with NZCV generation.
- `alu_mc` holds the FSM, the iteration datapath (accumulator, shifted multiplicand, remainder/quotient registers), the output registers and the handshake logic.

## Test plan
- Reset, then ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> after 1 cycle `result` = 64'h8000_0000_0000_0000, N=1, Z=0, C=0, V=1.
- SUB a=5, b=5 -> `result` = 0, Z=1, C=1, V=0; then SUB a=0, b=1 -> all ones, N=1, C=0.
- MUL a=64'h1_0000_0003, b=64'h5 -> `out_valid` exactly 65 cycles after accept, `result` = 64'h5_0000_000F. `in_ready` is low for the whole duration, and an `in_valid` presented during BUSY is ignored.
- UDIV a=100, b=7 -> `result` = 14 after 65 cycles. UDIV a=9, b=0 -> all ones, C=1, valid after 1 cycle.
- Back-pressure: hold `out_ready` = 0 for 10 cycles after `out_valid` -> `result` and flags stay stable and `in_ready` stays 0. Raising `out_ready` completes the operation, and `in_ready` = 1 on the next cycle.
- Assert `reset` 20 cycles into a MUL -> IDLE with all outputs at reset values next cycle and no `out_valid` pulse. A following AND a=64'hF0, b=64'h3C yields 64'h30.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and NZCV flag bundle for the multi-cycle ALU.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_UDIV  = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle AND/ORR/ADD/SUB/pass-B datapath with NZCV flag generation.
// Latency: purely combinational.
// Backpressure: none; the caller registers the outputs on accept.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output flags_t       f
);

  logic [N:0] sum;
  logic [N:0] diff;

  // Select the result by opcode; unknown codes give all ones. Carry for SUB is NOT borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = '1;
    f    = '0;
    case (op)
      ALU_AND:   y = a & b;
      ALU_ORR:   y = a | b;
      ALU_ADD: begin
        y   = sum[N-1:0];
        f.c = sum[N];
        f.v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        y   = diff[N-1:0];
        f.c = ~diff[N];
        f.v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_PASSB: y = b;
      default:   y = '1;
    endcase
    f.n = y[N-1];
    f.z = (y == '0);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: simple ops plus iterative unsigned MUL/UDIV, valid/ready on both sides.
// Latency: 1 cycle for simple ops and divide-by-zero, N+1 cycles for MUL/UDIV.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  alu_state_t     state;
  logic [CW-1:0]  cnt;
  logic           is_mul;
  // MUL: acc = partial product, areg = multiplicand (shifts left), breg = multiplier (shifts right).
  // UDIV: acc = remainder, areg = dividend shifting out / quotient shifting in, breg = divisor.
  logic [N-1:0]   acc;
  logic [N-1:0]   areg;
  logic [N-1:0]   breg;
  logic [N-1:0]   res_q;
  flags_t         flg;

  logic [N-1:0]   core_y;
  flags_t         core_f;

  logic [N-1:0]   acc_nx;
  logic [N-1:0]   areg_nx;
  logic [N-1:0]   breg_nx;
  logic [N:0]     rs;
  logic           ge;
  logic [N-1:0]   step_res;

  alu_core #(.N(N)) u_core (
    .op (ALUControl),
    .a  (a),
    .b  (b),
    .y  (core_y),
    .f  (core_f)
  );

  // One iteration step: shift-add for MUL, restoring subtract-shift for UDIV.
  always_comb begin
    rs = {acc, areg[N-1]};
    ge = (rs >= {1'b0, breg});
    if (is_mul) begin
      acc_nx  = breg[0] ? (acc + areg) : acc;
      areg_nx = areg << 1;
      breg_nx = breg >> 1;
      step_res = acc_nx;
    end else begin
      acc_nx  = ge ? (rs[N-1:0] - breg) : rs[N-1:0];
      areg_nx = {areg[N-2:0], ge};
      breg_nx = breg;
      step_res = areg_nx;
    end
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res_q     <= '0;
      flg       <= '0;
      cnt       <= '0;
      is_mul    <= 1'b0;
      acc       <= '0;
      areg      <= '0;
      breg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (ALUControl == ALU_MUL || (ALUControl == ALU_UDIV && b != '0)) begin
              is_mul   <= (ALUControl == ALU_MUL);
              acc      <= '0;
              areg     <= a;
              breg     <= b;
              cnt      <= CW'(N);
              in_ready <= 1'b0;
              state    <= BUSY;
            end else begin
              if (ALUControl == ALU_UDIV) begin
                // Divide by zero: all ones, carry flags the error.
                res_q <= '1;
                flg.n <= 1'b1;
                flg.z <= 1'b0;
                flg.c <= 1'b1;
                flg.v <= 1'b0;
              end else begin
                res_q <= core_y;
                flg   <= core_f;
              end
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc  <= acc_nx;
          areg <= areg_nx;
          breg <= breg_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            res_q     <= step_res;
            flg.n     <= step_res[N-1];
            flg.z     <= (step_res == '0);
            flg.c     <= 1'b0;
            flg.v     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign result   = res_q;
  assign zero     = flg.z;
  assign negative = flg.n;
  assign carry    = flg.c;
  assign overflow = flg.v;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against a reference model.
// Latency: checks exact accept-to-valid cycle counts.
// Backpressure: exercises held out_ready and out_ready already high.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {result, n, z, c, v} from plain arithmetic.
  function automatic logic [N+3:0] model(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] r;
    logic         c, v;
    logic [N:0]   wide;
    logic [N:0]   sx;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ALU_AND:   r = x & y;
      ALU_ORR:   r = x | y;
      ALU_ADD: begin
        wide = x + y + 65'd0;
        r = wide[N-1:0];
        c = wide[N];
        sx = {x[N-1], x} + {y[N-1], y};
        v = (sx[N] != sx[N-1]);
      end
      ALU_SUB: begin
        r = x - y;
        c = (x >= y);
        sx = {x[N-1], x} - {y[N-1], y};
        v = (sx[N] != sx[N-1]);
      end
      ALU_PASSB: r = y;
      ALU_MUL:   r = x * y;
      ALU_UDIV: begin
        if (y == 0) begin
          r = '1;
          c = 1'b1;
        end else begin
          r = x / y;
        end
      end
      default:   r = '1;
    endcase
    return {r, r[N-1], (r == 0), c, v};
  endfunction

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one op and follow it to completion, checking latency, result, flags and handshake.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] ai, input logic [N-1:0] bi,
                        input bit early, input int hold, input bit junk);
    logic [N+3:0] m;
    int lat;
    int exp_lat;
    m = model(op, ai, bi);
    exp_lat = (op == ALU_MUL || (op == ALU_UDIV && bi != 0)) ? N + 1 : 1;
    lat = 0;
    while (!in_ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid   = 1'b1;
    ALUControl = op;
    a          = ai;
    b          = bi;
    out_ready  = early;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) begin
        check("in_ready_busy", in_ready, 0);
        if (junk) begin
          in_valid   = 1'b1;
          a          = rnd64();
          b          = rnd64();
          ALUControl = 4'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end while (!out_valid && lat < 200);
    in_valid = 1'b0;
    check("latency", N'(lat), N'(exp_lat));
    check("result", result, m[N+3:4]);
    check("flags_nzcv", N'({negative, zero, carry, overflow}), N'(m[3:0]));
    if (!early) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_result", result, m[N+3:4]);
        check("hold_flags", N'({negative, zero, carry, overflow}), N'(m[3:0]));
        check("hold_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] ops[8];
    bit seen;
    ops = '{ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_MUL, ALU_UDIV, 4'b1111};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ALUControl = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", N'({negative, zero, carry, overflow}), 0);

    run_op(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0);
    run_op(ALU_SUB, 64'd5, 64'd5, 1'b0, 0, 1'b0);
    run_op(ALU_SUB, 64'd0, 64'd1, 1'b1, 0, 1'b0);
    run_op(ALU_MUL, 64'h1_0000_0003, 64'h5, 1'b0, 0, 1'b1);
    run_op(ALU_UDIV, 64'd100, 64'd7, 1'b0, 0, 1'b1);
    run_op(ALU_UDIV, 64'd9, 64'd0, 1'b0, 0, 1'b0);
    run_op(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 10, 1'b0);
    run_op(4'b0011, 64'h1234, 64'h5678, 1'b1, 0, 1'b0);

    // Reset mid-MUL: outputs return to reset values, no late out_valid.
    in_valid = 1'b1; ALUControl = ALU_MUL; a = 64'h123; b = 64'h456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", N'({negative, zero, carry, overflow}), 0);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_valid_after_rst", N'(seen), 0);
    run_op(ALU_AND, 64'hF0, 64'h3C, 1'b0, 0, 1'b0);

    // Randomized ops across all codes, with mixed back-pressure and junk during BUSY.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [N-1:0] ra, rb;
      op = ops[$urandom_range(7)];
      ra = rnd64();
      case ($urandom_range(3))
        0: rb = N'($urandom_range(15));
        1: rb = {32'd0, $urandom};
        default: rb = rnd64();
      endcase
      if ($urandom_range(3) == 0) ra = ra >> $urandom_range(63);
      run_op(op, ra, rb, 1'($urandom_range(1)), $urandom_range(3), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
